// File: rtl/pipe_front_end_if.sv
// Bundle of hazard, branch, fetch and decode signals around the IF/ID/EX front end.
// The master drives requests and fetch data; the slave (front end) returns pipeline state.
interface pipe_front_end_if;
  logic        PC_stall_i;
  logic        IF_ID_stall_i;
  logic        ID_EX_stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_i;
  logic [8:0]  ID_ctrl_i;
  logic [31:0] pc_o;
  logic [31:0] IF_ID_pc4_o;
  logic [31:0] IF_ID_instr_o;
  logic [8:0]  ID_EX_ctrl_o;
  logic [1:0]  ID_EX_M_o;

  modport master (
    output PC_stall_i, IF_ID_stall_i, ID_EX_stall_i, branch_taken_i,
           branch_target_i, instr_i, ID_ctrl_i,
    input  pc_o, IF_ID_pc4_o, IF_ID_instr_o, ID_EX_ctrl_o, ID_EX_M_o
  );

  modport slave (
    input  PC_stall_i, IF_ID_stall_i, ID_EX_stall_i, branch_taken_i,
           branch_target_i, instr_i, ID_ctrl_i,
    output pc_o, IF_ID_pc4_o, IF_ID_instr_o, ID_EX_ctrl_o, ID_EX_M_o
  );
endinterface

// File: rtl/pipe_front_end.sv
// Pipeline front end: PC register, IF/ID and ID/EX control registers with stall/flush,
// saturating event counters, stall-consistency error flag and a stall watchdog.
module pipe_front_end #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipe_front_end_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic            stall_err_o,
  output logic            hung_o
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CTL_W = 9;
  localparam int unsigned RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {RUN, STALL, HUNG} state_t;

  logic [PC_W-1:0]  pc_q, pc4_q, instr_q;
  logic [CTL_W-1:0] ctrl_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             err_q, hung_q;
  state_t           state_q;
  logic [RUN_W-1:0] run_q;

  logic br, ps, ifs, ids, stall_ev;
  assign br       = bus.branch_taken_i;
  assign ps       = bus.PC_stall_i;
  assign ifs      = bus.IF_ID_stall_i;
  assign ids      = bus.ID_EX_stall_i;
  assign stall_ev = ps & ~br;

  // Pipeline registers and event bookkeeping; branch flush outranks stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      pc4_q       <= '0;
      instr_q     <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (br)       pc_q <= bus.branch_target_i;
      else if (!ps) pc_q <= pc_q + PC_W'(4);

      if (br) begin
        pc4_q   <= '0;
        instr_q <= '0;
      end else if (!ifs) begin
        pc4_q   <= pc_q + PC_W'(4);
        instr_q <= bus.instr_i;
      end

      ctrl_q <= (ids || br) ? '0 : bus.ID_ctrl_i;

      if (stall_ev && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br && !(&flush_cnt_q))       flush_cnt_q <= flush_cnt_q + CNT_W'(1);

      if (!br && !((ps == ifs) && (ifs == ids))) err_q <= 1'b1;
    end
  end

  // Watchdog: counts consecutive fetch stalls, latches HUNG once the run overstays.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      run_q   <= '0;
      hung_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_ev) begin
            state_q <= STALL;
            run_q   <= RUN_W'(1);
          end
        end
        STALL: begin
          if (!stall_ev) begin
            state_q <= RUN;
            run_q   <= '0;
          end else if (run_q == RUN_W'(MAX_STALL)) begin
            state_q <= HUNG;
            hung_q  <= 1'b1;
          end else begin
            run_q <= run_q + RUN_W'(1);
          end
        end
        HUNG:    hung_q  <= 1'b1;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.IF_ID_pc4_o   = pc4_q;
  assign bus.IF_ID_instr_o = instr_q;
  assign bus.ID_EX_ctrl_o  = ctrl_q;
  assign bus.ID_EX_M_o     = ctrl_q[6:5];
  assign stall_cnt_o       = stall_cnt_q;
  assign flush_cnt_o       = flush_cnt_q;
  assign stall_err_o       = err_q;
  assign hung_o            = hung_q;

endmodule

// File: doc/pipe_front_end.md
PIPE_FRONT_END -- requirements
Module: pipe_front_end

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush counters.
REQ-003 Parameter MAX_STALL, default 8, number of consecutive stall cycles before the hang flag sets.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 PC_stall_i  input  1  hazard unit request: hold PC.
REQ-007 IF_ID_stall_i  input  1  hazard unit request: hold IF/ID register.
REQ-008 ID_EX_stall_i  input  1  hazard unit request: insert bubble into ID/EX control.
REQ-009 branch_taken_i  input  1  redirect and flush request from the branch decision.
REQ-010 branch_target_i  input  32  redirect address.
REQ-011 instr_i  input  32  instruction memory read data for pc_o, combinational.
REQ-012 ID_ctrl_i  input  9  decoded control {WB[1:0], M[1:0], EX[4:0]}.
REQ-013 pc_o  output  32  current fetch PC.
REQ-014 IF_ID_pc4_o  output  32  IF/ID latched PC+4.
REQ-015 IF_ID_instr_o  output  32  IF/ID latched instruction.
REQ-016 ID_EX_ctrl_o  output  9  ID/EX control bundle.
REQ-017 ID_EX_M_o  output  2  ID_EX_ctrl_o[6:5], returned to the hazard unit.
REQ-018 stall_cnt_o, flush_cnt_o  output  CNT_W each  saturating event counters.
REQ-019 stall_err_o, hung_o  output  1 each  sticky fault flags.

Function
REQ-020 PC update priority: branch_taken_i loads branch_target_i; otherwise PC_stall_i holds; otherwise PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 IF/ID update priority: branch_taken_i loads instr 0 and pc4 0 (flush); otherwise IF_ID_stall_i holds both; otherwise latches instr_i and pc_o+4.
REQ-022 ID/EX control loads 9'b0 (bubble) when ID_EX_stall_i or branch_taken_i; otherwise loads ID_ctrl_i. Stall inserts a bubble and never holds.
REQ-023 All pipeline effects appear one cycle after the sampled inputs; no combinational path runs from any input to any output.
REQ-024 Each stall input acts independently. stall_err_o sets when the three stall inputs are not all equal in a cycle where branch_taken_i=0, and stays set until reset.
REQ-025 stall_cnt_o increments in each cycle with PC_stall_i=1 and branch_taken_i=0, and saturates at all-ones.
REQ-026 flush_cnt_o increments in each cycle with branch_taken_i=1, and saturates at all-ones.
REQ-027 Watchdog FSM states: RUN, STALL, HUNG, plus a run counter.
REQ-028 RUN to STALL when PC_stall_i=1 and branch_taken_i=0; the run counter loads 1.
REQ-029 In STALL, the run counter increments each cycle that stall continues.
REQ-030 STALL to RUN when PC_stall_i=0 or branch_taken_i=1; the run counter clears.
REQ-031 STALL to HUNG when stall continues and the run counter equals MAX_STALL.
REQ-032 HUNG is terminal until reset; hung_o=1 only in HUNG; pipeline behaviour is unaffected by FSM state.
REQ-033 Simultaneous branch_taken_i and any stall: branch wins for PC and IF/ID; ID/EX still bubbles; the stall counter does not count.

Reset
REQ-034 rst_i=1 at a clock edge sets: pc_o=RESET_PC, IF/ID fields 0, ID_EX_ctrl_o 0, both counters 0, both flags 0, FSM RUN, run counter 0.
REQ-035 Reset overrides all other inputs in the same cycle, including mid-stall and mid-branch.
REQ-036 Outputs reflect reset values on the first edge after rst_i deasserts, until the next edge.

Verification
REQ-037 Sequential fetch: reset, instr_i=32'h1234_5678, no stalls, 3 cycles -> pc_o 0,4,8,12; IF_ID_pc4_o=12; IF_ID_instr_o=32'h1234_5678.
REQ-038 Load-use: all three stalls high for 1 cycle at pc_o=8 with ID_ctrl_i=9'h1FF -> pc_o holds 8; IF/ID holds; ID_EX_ctrl_o=0; stall_cnt_o=1; stall_err_o=0.
REQ-039 Branch during stall: PC_stall_i=1 and branch_taken_i=1 with target 32'h100 -> pc_o=32'h100; IF_ID_instr_o=0; flush_cnt_o=1; stall_cnt_o unchanged.
REQ-040 Mismatch: PC_stall_i=1 and IF_ID_stall_i=0 -> stall_err_o=1 next cycle and remains 1 after the inputs agree.
REQ-041 Hang: with MAX_STALL=8, PC_stall_i held high for 9 cycles -> hung_o=1 after the 9th edge; a 7-cycle stall then release leaves hung_o=0.
REQ-042 Wrap and saturation: RESET_PC=32'hFFFF_FFF8 with 2 free cycles -> pc_o=0; with CNT_W=4, 20 stall cycles -> stall_cnt_o=4'hF.
